// File: rtl/axis_spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ AXIS requesters, with watchdog.
// Define SPI_ARB_STATS_EN to enable the stat_xfers/stat_timeouts counters.
module axis_spi_arbiter #(
  parameter int unsigned             NUM_REQ      = 4,
  parameter int unsigned             DATA_WIDTH   = 32,
  parameter int unsigned             TIMEOUT      = 4096,
  parameter logic [DATA_WIDTH-1:0]   INVALID_DATA = 32'hcccccccc
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_req_data,
  input  logic [NUM_REQ-1:0]            s_req_valid,
  output logic [NUM_REQ-1:0]            s_req_ready,
  output logic [DATA_WIDTH-1:0]         s_rsp_data,
  output logic [NUM_REQ-1:0]            s_rsp_valid,
  input  logic [NUM_REQ-1:0]            s_rsp_ready,
  output logic [DATA_WIDTH-1:0]         m_tx_data,
  output logic                          m_tx_valid,
  input  logic                          m_tx_ready,
  input  logic [DATA_WIDTH-1:0]         m_rx_data,
  input  logic                          m_done_valid,
  output logic                          m_done_ready,
  output logic                          busy,
  output logic                          err_timeout,
  output logic [31:0]                   stat_xfers,
  output logic [15:0]                   stat_timeouts
);

  localparam int unsigned GntW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [GntW-1:0]       ptr_q, ptr_d;
  logic [GntW-1:0]       gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rsp_q, rsp_d;
  logic [WdW-1:0]        wd_q, wd_d;
  logic                  err_q, err_d;

  logic                  hit;
  logic [GntW-1:0]       hit_idx;
  logic [GntW-1:0]       cand;
  logic                  wd_last;
  logic                  rsp_hs;
  logic                  timeout_evt;
  logic [DATA_WIDTH-1:0] req_words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_words[i] = s_req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester at or after ptr_q, wrapping.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = GntW'((32'(ptr_q) + i) % NUM_REQ);
      if (!hit && s_req_valid[cand]) begin
        hit     = 1'b1;
        hit_idx = cand;
      end
    end
  end

  assign wd_last     = (wd_q == WdW'(TIMEOUT - 1));
  assign rsp_hs      = (state_q == StResp) && s_rsp_ready[gnt_q];
  assign timeout_evt = (state_q == StWait) && !m_done_valid && wd_last;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (hit) state_d = StIssue;
      StIssue: if (m_tx_ready) state_d = StWait;
      StWait:  if (m_done_valid || wd_last) state_d = StResp;
      StResp:  if (rsp_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_req_ready  = '0;
    s_rsp_valid  = '0;
    m_tx_valid   = 1'b0;
    m_done_ready = 1'b0;
    busy         = (state_q != StIdle);
    case (state_q)
      StIdle: begin
        m_done_ready = 1'b1;
        if (hit) s_req_ready[hit_idx] = 1'b1;
      end
      StIssue: m_tx_valid = 1'b1;
      StWait:  m_done_ready = 1'b1;
      StResp:  s_rsp_valid[gnt_q] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ptr_d  = ptr_q;
    gnt_d  = gnt_q;
    data_d = data_q;
    rsp_d  = rsp_q;
    wd_d   = wd_q;
    err_d  = err_q;
    case (state_q)
      StIdle: if (hit) begin
        gnt_d  = hit_idx;
        data_d = req_words[hit_idx];
      end
      StIssue: if (m_tx_ready) wd_d = '0;
      StWait: begin
        wd_d = wd_q + WdW'(1);
        // A done arriving on the last watchdog cycle still wins.
        if (m_done_valid) begin
          rsp_d = m_rx_data;
        end else if (wd_last) begin
          rsp_d = INVALID_DATA;
          err_d = 1'b1;
        end
      end
      StResp: if (rsp_hs) ptr_d = GntW'((32'(gnt_q) + 1) % NUM_REQ);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      data_q <= '0;
      rsp_q  <= '0;
      wd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      data_q <= data_d;
      rsp_q  <= rsp_d;
      wd_q   <= wd_d;
      err_q  <= err_d;
    end
  end

  assign m_tx_data   = data_q;
  assign s_rsp_data  = rsp_q;
  assign err_timeout = err_q;

`ifdef SPI_ARB_STATS_EN
  logic [31:0] xfers_q;
  logic [15:0] tos_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfers_q <= '0;
      tos_q   <= '0;
    end else begin
      if (rsp_hs) xfers_q <= xfers_q + 32'd1;
      if (timeout_evt && (tos_q != 16'hffff)) tos_q <= tos_q + 16'd1;
    end
  end

  assign stat_xfers    = xfers_q;
  assign stat_timeouts = tos_q;
`else
  assign stat_xfers    = '0;
  assign stat_timeouts = '0;
`endif

endmodule

// File: doc/axis_spi_arbiter.md
Name: axis_spi_arbiter

Overview:
- Shares one fixed-width SPI master (AXIS tx word in; rx word plus done/interrupt handshake out) between NUM_REQ independent AXIS requesters.
- Round-robin grant, exactly one transaction in flight.
- Captures the rx word when the master signals done and routes it back to the originating requester.
- A per-transaction watchdog prevents a stuck master from hanging the bus.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, SPI word width, also the request/response width.
- TIMEOUT, 4096, clk cycles allowed from tx accept to done before abort (>=2).
- INVALID_DATA, 32'hcccccccc, response word returned on timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_req_data  in  NUM_REQ*DATA_WIDTH  request words; requester i uses slice i.
- s_req_valid  in  NUM_REQ  request valid per requester.
- s_req_ready  out  NUM_REQ  request accept, one-hot.
- s_rsp_data  out  DATA_WIDTH  response word, shared by all requesters.
- s_rsp_valid  out  NUM_REQ  response valid, one-hot to owner.
- s_rsp_ready  in  NUM_REQ  response ready per requester.
- m_tx_data  out  DATA_WIDTH  word to SPI master.
- m_tx_valid  out  1  tx valid.
- m_tx_ready  in  1  tx ready.
- m_rx_data  in  DATA_WIDTH  last received SPI word.
- m_done_valid  in  1  transaction-complete flag from master.
- m_done_ready  out  1  clears done flag.
- busy  out  1  high when state != IDLE.
- err_timeout  out  1  sticky; set on any timeout, cleared only by rst.
- stat_xfers  out  32  completed-transaction count (see Optional Feature).
- stat_timeouts  out  16  timeout count (see Optional Feature).

Behaviour:
- Reset: state=IDLE, rr pointer=0, all ready/valid outputs 0, m_tx_data=0, s_rsp_data=0, err_timeout=0, stats=0. m_done_ready=1, as in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Search s_req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - First hit g: s_req_ready[g]=1 combinationally in that cycle. Latch data slice g and grant=g. Next state ISSUE.
  - No hit: remain in IDLE.
  - m_done_ready=1 to drain any stale done flag.
- ISSUE:
  - m_tx_valid=1, m_tx_data=latched word.
  - On m_tx_ready: watchdog=0, go to WAIT.
  - m_tx_valid never drops before ready; data is stable.
- WAIT:
  - m_done_ready=1; watchdog increments each cycle.
  - m_done_valid: latch m_rx_data into s_rsp_data, go to RESP.
  - Else if watchdog==TIMEOUT-1: s_rsp_data=INVALID_DATA, set err_timeout, go to RESP.
  - Done and timeout in the same cycle: done wins.
- RESP:
  - s_rsp_valid[grant]=1, hold until s_rsp_ready[grant].
  - On handshake: ptr=(grant+1) mod NUM_REQ, go to IDLE.
  - Other requesters' ready bits are ignored.
- m_done_ready=0 in ISSUE and RESP.
- Latency, all ready/valid high: request accept -> m_tx_valid next cycle. Done -> s_rsp_valid next cycle. Response handshake -> next grant possible next cycle.
- Fairness: a continuously requesting input waits at most NUM_REQ-1 transactions.
- Requester deasserting valid without ready: allowed, no grant recorded.
- rst mid-transaction: FSM returns to IDLE immediately and the in-flight response is dropped. The master is reset by the same rst.

Optional Feature:
- Macro: SPI_ARB_STATS_EN.
- Defined:
  - stat_xfers increments on every RESP handshake, including timeouts; wraps at 2^32.
  - stat_timeouts increments on each timeout and saturates at 16'hffff.
  - Both are cleared by rst.
- Undefined: both ports are tied to 0 and no counter logic is present.

Test Plan:
- Single requester, NUM_REQ=4: req1 sends 32'h8000_1234, master returns 32'h0000_00a5 after 70 cycles -> s_rsp_valid=4'b0010, s_rsp_data=32'h0000_00a5; stat_xfers=1.
- All four valid continuously, ptr=0 -> grant order 0,1,2,3,0; no requester granted twice before the others are served.
- Master never asserts done, TIMEOUT=16 -> s_rsp_data=32'hcccccccc exactly 16 cycles after tx accept; err_timeout=1 stays set; stat_timeouts=1; next request is served normally.
- s_rsp_ready low for 10 cycles in RESP -> s_rsp_valid and s_rsp_data held, busy=1, no new s_req_ready pulse.
- Stale m_done_valid=1 while in IDLE -> drained, with no response generated and no state change.
- rst asserted in WAIT -> next cycle busy=0, all valids=0, ptr=0; a new request is granted normally.
